// File: rtl/mux_scan_n.sv
// NCH-channel W-bit registered mux with manual select or auto-scan rotation and active-low strobe.
// Optional: define MUX_SCAN_BLANK_GAP_EN to blank An for the first dwell cycle of each new scan channel (DIV=1 then always blanks; misuse).
module mux_scan_n #(
  parameter int unsigned W    = 4,
  parameter int unsigned NCH  = 4,
  parameter int unsigned SELW = 2,
  parameter int unsigned DIV  = 4
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [NCH*W-1:0]  D,
  input  logic [SELW-1:0]   S,
  input  logic              Mode,
  input  logic              En,
  output logic [W-1:0]      Out,
  output logic [NCH-1:0]    An,
  output logic [SELW-1:0]   Sel,
  output logic              Tick
);

  localparam int unsigned    CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DIV - 1);
  localparam logic [SELW-1:0] SEL_LAST = SELW'(NCH - 1);
`ifdef MUX_SCAN_BLANK_GAP_EN
  localparam bit BLANK_GAP = 1'b1;
`else
  localparam bit BLANK_GAP = 1'b0;
`endif

  typedef enum logic {MODE_MANUAL = 1'b0, MODE_SCAN = 1'b1} mode_e;

  logic [W-1:0]    out_q,  out_d;
  logic [NCH-1:0]  an_q,   an_d;
  logic [SELW-1:0] sel_q,  sel_d;
  logic            tick_q, tick_d;
  logic [CW-1:0]   cnt_q,  cnt_d;
  mode_e           mode_q, mode_d;
  logic [SELW-1:0] nxt;

  // Indices at or above NCH yield zero data and a blank strobe.
  function automatic logic [W-1:0] chan_data(input logic [NCH*W-1:0] d,
                                             input logic [SELW-1:0] idx);
    chan_data = '0;
    for (int unsigned k = 0; k < NCH; k++)
      if (SELW'(k) == idx) chan_data = d[k*W +: W];
  endfunction

  function automatic logic [NCH-1:0] onehot_n(input logic [SELW-1:0] idx);
    onehot_n = '1;
    for (int unsigned k = 0; k < NCH; k++)
      if (SELW'(k) == idx) onehot_n[k] = 1'b0;
  endfunction

  assign nxt = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;

  always_comb begin
    out_d  = out_q;
    an_d   = an_q;
    sel_d  = sel_q;
    tick_d = 1'b0;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    if (!En) begin
      an_d = '1;
    end else begin
      mode_d = Mode ? MODE_SCAN : MODE_MANUAL;
      if (!Mode) begin
        sel_d = S;
        out_d = chan_data(D, S);
        an_d  = onehot_n(S);
        cnt_d = '0;
      end else if (mode_q == MODE_MANUAL) begin
        sel_d  = '0;
        out_d  = chan_data(D, '0);
        an_d   = BLANK_GAP ? '1 : onehot_n('0);
        cnt_d  = '0;
        tick_d = 1'b1;
      end else if (cnt_q == CNT_LAST) begin
        sel_d  = nxt;
        out_d  = chan_data(D, nxt);
        an_d   = BLANK_GAP ? '1 : onehot_n(nxt);
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        // Re-deriving An from Sel (rather than holding) also restores the strobe after an En freeze or blank gap.
        cnt_d = cnt_q + 1'b1;
        out_d = chan_data(D, sel_q);
        an_d  = onehot_n(sel_q);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      out_q  <= '0;
      an_q   <= '1;
      sel_q  <= '0;
      tick_q <= 1'b0;
      cnt_q  <= '0;
      mode_q <= MODE_MANUAL;
    end else begin
      out_q  <= out_d;
      an_q   <= an_d;
      sel_q  <= sel_d;
      tick_q <= tick_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
    end
  end

  assign Out  = out_q;
  assign An   = an_q;
  assign Sel  = sel_q;
  assign Tick = tick_q;

endmodule

// File: tb/tb_mux_scan_n.sv
// Randomised self-checking bench for mux_scan_n against an elapsed-edge arithmetic model.
module tb_mux_scan_n;
  localparam int W = 4, NCH = 4, SELW = 2, DIV = 4;
`ifdef MUX_SCAN_BLANK_GAP_EN
  localparam bit GAP = 1'b1;
`else
  localparam bit GAP = 1'b0;
`endif

  logic            Clk = 1'b0;
  logic            Reset_n;
  logic [NCH*W-1:0] D;
  logic [SELW-1:0] S;
  logic            Mode, En;
  logic [W-1:0]    Out;
  logic [NCH-1:0]  An;
  logic [SELW-1:0] Sel;
  logic            Tick;

  logic [3*4-1:0]  D3;
  logic [1:0]      S3, Sel3;
  logic            Mode3, En3, Tick3;
  logic [3:0]      Out3;
  logic [2:0]      An3;

  int vectors = 0, errors = 0;

  logic [W-1:0]    m_out;
  logic [NCH-1:0]  m_an;
  logic [SELW-1:0] m_sel;
  logic            m_tick;
  int              m_n;
  bit              m_prev;

  always #5 Clk = ~Clk;

  mux_scan_n #(.W(W), .NCH(NCH), .SELW(SELW), .DIV(DIV)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .D(D), .S(S), .Mode(Mode), .En(En),
    .Out(Out), .An(An), .Sel(Sel), .Tick(Tick));

  mux_scan_n #(.W(4), .NCH(3), .SELW(2), .DIV(2)) dut3 (
    .Clk(Clk), .Reset_n(Reset_n), .D(D3), .S(S3), .Mode(Mode3), .En(En3),
    .Out(Out3), .An(An3), .Sel(Sel3), .Tick(Tick3));

  // Scan position is the count of enabled scan edges since the restart edge.
  task automatic model_update();
    int ch;
    if (!Reset_n) begin
      m_out = '0; m_an = '1; m_sel = '0; m_tick = 1'b0; m_n = 0; m_prev = 1'b0;
    end else if (!En) begin
      m_an = '1; m_tick = 1'b0;
    end else if (!Mode) begin
      m_sel = S; m_tick = 1'b0; m_n = 0; m_prev = 1'b0;
      if (int'(S) < NCH) begin
        m_out = D[int'(S)*W +: W]; m_an = ~(NCH'(1) << S);
      end else begin
        m_out = '0; m_an = '1;
      end
    end else begin
      if (!m_prev) m_n = 0; else m_n++;
      ch = (m_n / DIV) % NCH;
      m_sel = SELW'(ch); m_out = D[ch*W +: W]; m_tick = (m_n % DIV == 0);
      m_an = ~(NCH'(1) << ch);
      if (GAP && m_tick) m_an = '1;
      m_prev = 1'b1;
    end
  endtask

  task automatic step();
    model_update();
    @(posedge Clk); #1;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; Mode = 1'b1; En = 1'b1; S = '0; D = {4'd8, 4'd4, 4'd2, 4'd1};
    D3 = {4'h7, 4'h5, 4'h3}; S3 = '0; Mode3 = 1'b0; En3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (Out !== 4'd0 || An !== 4'b1111 || Sel !== 2'd0 || Tick !== 1'b0) begin
        errors++;
        $display("FAIL reset cyc %0d: got Out=%h An=%b Sel=%0d Tick=%b want 0 1111 0 0", i, Out, An, Sel, Tick);
      end
    end
    Reset_n = 1'b1;
    step();
    vectors++;
    if (Out !== 4'd1 || Sel !== 2'd0 || Tick !== 1'b1 || An !== (GAP ? 4'b1111 : 4'b1110)) begin
      errors++;
      $display("FAIL reset_release: got Out=%h An=%b Sel=%0d Tick=%b want 1 %b 0 1", Out, An, Sel, Tick, GAP ? 4'b1111 : 4'b1110);
    end
  endtask

  task automatic test_manual();
    Mode = 1'b0; En = 1'b1;
    for (int s = 0; s < 4; s++) begin
      S = SELW'(s);
      for (int c = 0; c < 10; c++) begin
        step();
        vectors++;
        if (Out !== 4'(1 << s) || An !== ~4'(1 << s) || Sel !== SELW'(s) || Tick !== 1'b0 ||
            Out !== m_out || An !== m_an) begin
          errors++;
          $display("FAIL manual s=%0d c=%0d: got Out=%h An=%b Sel=%0d Tick=%b want %h %b %0d 0",
                   s, c, Out, An, Sel, Tick, 4'(1 << s), ~4'(1 << s), s);
        end
      end
    end
  endtask

  task automatic test_scan();
    int ticks = 0;
    Mode = 1'b1; S = 2'd3;
    for (int e = 1; e <= 20; e++) begin
      step();
      vectors++;
      if (Out !== m_out || An !== m_an || Sel !== m_sel || Tick !== m_tick ||
          Tick !== ((e - 1) % DIV == 0)) begin
        errors++;
        $display("FAIL scan edge %0d: got Out=%h An=%b Sel=%0d Tick=%b want %h %b %0d %b",
                 e, Out, An, Sel, Tick, m_out, m_an, m_sel, m_tick);
      end
      if (Tick === 1'b1) ticks++;
    end
    vectors++;
    if (ticks != 5) begin
      errors++;
      $display("FAIL scan_tick_count: got %0d want 5", ticks);
    end
  endtask

  task automatic test_live_update();
    int guard = 0;
    while (!(m_sel == 2'd2 && m_n % DIV == 1) && guard < 40) begin
      step(); guard++;
      vectors++;
      if (Out !== m_out || An !== m_an || Sel !== m_sel || Tick !== m_tick) begin
        errors++;
        $display("FAIL live_seek: got Out=%h An=%b Sel=%0d Tick=%b want %h %b %0d %b",
                 Out, An, Sel, Tick, m_out, m_an, m_sel, m_tick);
      end
    end
    vectors++;
    if (guard >= 40) begin
      errors++;
      $display("FAIL live_timeout: got %0d cycles want <40", guard);
    end
    D[2*W +: W] = 4'd6;
    step();
    vectors++;
    if (Out !== 4'd6 || Sel !== 2'd2 || Tick !== 1'b0) begin
      errors++;
      $display("FAIL live_update: got Out=%h Sel=%0d Tick=%b want 6 2 0", Out, Sel, Tick);
    end
  endtask

  task automatic test_en_freeze();
    int guard = 0;
    logic [W-1:0] hold_out;
    logic [SELW-1:0] hold_sel;
    while (m_n % DIV != 2 && guard < 10) begin step(); guard++; end
    hold_out = Out; hold_sel = Sel;
    En = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (An !== 4'b1111 || Tick !== 1'b0 || Out !== hold_out || Sel !== hold_sel) begin
        errors++;
        $display("FAIL freeze %0d: got Out=%h An=%b Sel=%0d Tick=%b want %h 1111 %0d 0",
                 i, Out, An, Sel, Tick, hold_out, hold_sel);
      end
    end
    En = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if (Tick !== (i == 1) || Out !== m_out || An !== m_an || Sel !== m_sel) begin
        errors++;
        $display("FAIL resume %0d: got Out=%h An=%b Sel=%0d Tick=%b want %h %b %0d %b",
                 i, Out, An, Sel, Tick, m_out, m_an, m_sel, i == 1);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      Reset_n = ($urandom_range(0, 99) >= 3);
      En      = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 24) == 0) Mode = ~Mode;
      S = SELW'($urandom);
      if ($urandom_range(0, 3) == 0) D = NCH*W'($urandom);
      step();
      vectors++;
      if (Out !== m_out || An !== m_an || Sel !== m_sel || Tick !== m_tick) begin
        errors++;
        $display("FAIL random %0d: got Out=%h An=%b Sel=%0d Tick=%b want %h %b %0d %b",
                 i, Out, An, Sel, Tick, m_out, m_an, m_sel, m_tick);
      end
    end
    Reset_n = 1'b1;
  endtask

  task automatic test_illegal_nch3();
    int n;
    Mode3 = 1'b0; En3 = 1'b1; S3 = 2'd3;
    step();
    vectors++;
    if (Out3 !== 4'd0 || An3 !== 3'b111 || Sel3 !== 2'd3) begin
      errors++;
      $display("FAIL illegal_sel: got Out=%h An=%b Sel=%0d want 0 111 3", Out3, An3, Sel3);
    end
    S3 = 2'd1;
    step();
    vectors++;
    if (Out3 !== 4'h5 || An3 !== 3'b101 || Sel3 !== 2'd1) begin
      errors++;
      $display("FAIL nch3_manual: got Out=%h An=%b Sel=%0d want 5 101 1", Out3, An3, Sel3);
    end
    Mode3 = 1'b1;
    for (n = 0; n < 14; n++) begin
      step();
      vectors++;
      if (Sel3 === 2'd3 || Sel3 !== 2'((n / 2) % 3) || Tick3 !== (n % 2 == 0)) begin
        errors++;
        $display("FAIL nch3_scan n=%0d: got Sel=%0d Tick=%b want %0d %b", n, Sel3, Tick3, (n / 2) % 3, n % 2 == 0);
      end
    end
    En3 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_manual();
    test_scan();
    test_live_update();
    test_en_freeze();
    test_random();
    test_illegal_nch3();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
